cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the fixed-width combinational lookahead adders in the datapath library.
- The operand width is split into BLK-bit lookahead blocks. Blocks are grouped into register stages, and inter-stage carries ripple through pipeline registers (skewed operands, de-skewed sum).
- Valid/ready handshakes on both sides. One result per cycle at full throughput.
- Sits between operand-select logic and the ALU result mux.

---
 rtl/cla_pipe_adder_pkg.sv | 17 +
 rtl/cla_block.sv | 45 ++++
 rtl/cla_pipe_adder.sv | 176 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pipe_adder_pkg.sv
// Elaboration helpers shared by the pipelined carry-lookahead adder.
package cla_pipe_adder_pkg;

    function automatic int unsigned num_stages(input int unsigned width,
                                               input int unsigned blk,
                                               input int unsigned blk_per_stage);
        return width / (blk * blk_per_stage);
    endfunction

    function automatic bit params_legal(input int unsigned width,
                                        input int unsigned blk,
                                        input int unsigned blk_per_stage);
        return (blk != 0) && (blk_per_stage != 0) && (width != 0) &&
               ((width % (blk * blk_per_stage)) == 0);
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLK-bit carry-lookahead cell: bit carries and block G/P come from a
// flattened lookahead expansion rather than a ripple chain.
module cla_block #(
    parameter int unsigned BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           g,
    output logic           p,
    output logic           cout
);
    logic [BLK-1:0] w_gen;
    logic [BLK-1:0] w_prop;
    logic [BLK:0]   w_c;
    logic           w_term;
    logic           w_pre;

    assign w_gen  = a & b;
    assign w_prop = a ^ b;

    always_comb begin
        w_c    = '0;
        w_c[0] = cin;
        w_term = 1'b0;
        w_pre  = 1'b0;
        g      = 1'b0;
        for (int i = 0; i < int'(BLK); i++) begin
            // Carry into bit i+1 = G[i:0] | P[i:0] & cin, expanded over all lower bits.
            w_term = w_gen[i];
            w_pre  = w_prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_term = w_term | (w_pre & w_gen[j]);
                w_pre  = w_pre & w_prop[j];
            end
            w_c[i+1] = w_term | (w_pre & cin);
            g        = w_term;
        end
    end

    assign p    = &w_prop;
    assign s    = w_prop ^ w_c[BLK-1:0];
    assign cout = w_c[BLK];
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one operand slice per stage, inter-stage carry
// registered, upper operands skewed forward and lower sum slices de-skewed to the output.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned BLK           = 4,
    parameter int unsigned BLK_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int unsigned NUM_STAGES = num_stages(WIDTH, BLK, BLK_PER_STAGE);
    localparam int unsigned SW         = BLK * BLK_PER_STAGE;
    localparam int unsigned LAST       = NUM_STAGES - 1;
    // Triangular packing: stage k keeps operand bits [(k+1)*SW, WIDTH) and sum bits [0, (k+1)*SW).
    localparam int unsigned SKEW_W = (NUM_STAGES > 1) ?
                                     (LAST * WIDTH - SW * LAST * NUM_STAGES / 2) : 1;
    localparam int unsigned DSK_W  = SW * NUM_STAGES * (NUM_STAGES + 1) / 2;

    if (!params_legal(WIDTH, BLK, BLK_PER_STAGE)) begin : g_bad_params
        $error("cla_pipe_adder: WIDTH must be a nonzero multiple of BLK*BLK_PER_STAGE");
    end

    logic [NUM_STAGES-1:0]          r_valid;
    logic [NUM_STAGES-1:0]          r_carry;
    logic [SKEW_W-1:0]              r_skew_a;
    logic [SKEW_W-1:0]              r_skew_b;
    logic [DSK_W-1:0]               r_dsk;
    logic                           r_ovf;
    logic                           w_advance;
    logic [WIDTH-1:0]               w_b_eff;
    logic                           w_cin0;
    logic                           w_msb_carry;
    logic [NUM_STAGES-1:0][SW-1:0]  w_sa;
    logic [NUM_STAGES-1:0][SW-1:0]  w_sb;
    logic [NUM_STAGES-1:0][SW-1:0]  w_ss;
    logic [NUM_STAGES-1:0]          w_cin;
    logic [NUM_STAGES-1:0]          w_cout;
    logic [NUM_STAGES-1:0]          w_vin;

    assign w_advance = !r_valid[LAST] || out_ready;
    assign in_ready  = w_advance;
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin0    = sub | c_in;

    for (genvar k = 0; k < int'(NUM_STAGES); k++) begin : g_stage
        localparam int unsigned DSK_OFF = SW * k * (k + 1) / 2;

        logic [(k+1)*SW-1:0]      w_dsk_nxt;
        logic [BLK_PER_STAGE-1:0] w_bg;
        logic [BLK_PER_STAGE-1:0] w_bp;
        logic [BLK_PER_STAGE-1:0] w_bco;
        logic [BLK_PER_STAGE:0]   w_bc;
        logic                     w_term;
        logic                     w_pre;

        if (k == 0) begin : g_first
            assign w_sa[k]   = a[SW-1:0];
            assign w_sb[k]   = w_b_eff[SW-1:0];
            assign w_cin[k]  = w_cin0;
            assign w_vin[k]  = in_valid;
            assign w_dsk_nxt = w_ss[k];
        end else begin : g_next
            localparam int unsigned PREV_SKEW = (k - 1) * WIDTH - SW * (k - 1) * k / 2;
            localparam int unsigned PREV_DSK  = SW * (k - 1) * k / 2;
            assign w_sa[k]   = r_skew_a[PREV_SKEW +: SW];
            assign w_sb[k]   = r_skew_b[PREV_SKEW +: SW];
            assign w_cin[k]  = r_carry[k-1];
            assign w_vin[k]  = r_valid[k-1];
            assign w_dsk_nxt = {w_ss[k], r_dsk[PREV_DSK +: k*SW]};
        end

        // Block carries by lookahead over block G/P, same expansion as inside cla_block.
        always_comb begin
            w_bc    = '0;
            w_bc[0] = w_cin[k];
            w_term  = 1'b0;
            w_pre   = 1'b0;
            for (int j = 0; j < int'(BLK_PER_STAGE); j++) begin
                w_term = w_bg[j];
                w_pre  = w_bp[j];
                for (int i = j - 1; i >= 0; i--) begin
                    w_term = w_term | (w_pre & w_bg[i]);
                    w_pre  = w_pre & w_bp[i];
                end
                w_bc[j+1] = w_term | (w_pre & w_cin[k]);
            end
        end

        for (genvar j = 0; j < int'(BLK_PER_STAGE); j++) begin : g_blk
            cla_block #(
                .BLK (BLK)
            ) u_blk (
                .a    (w_sa[k][j*BLK +: BLK]),
                .b    (w_sb[k][j*BLK +: BLK]),
                .cin  (w_bc[j]),
                .s    (w_ss[k][j*BLK +: BLK]),
                .g    (w_bg[j]),
                .p    (w_bp[j]),
                .cout (w_bco[j])
            );

            a_blk_cout: assert property (@(posedge clk) disable iff (rst)
                                         w_bco[j] == w_bc[j+1]);
        end

        assign w_cout[k] = w_bc[BLK_PER_STAGE];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid[k]                 <= 1'b0;
                r_carry[k]                 <= 1'b0;
                r_dsk[DSK_OFF +: (k+1)*SW] <= '0;
            end else if (w_advance) begin
                r_valid[k]                 <= w_vin[k];
                r_carry[k]                 <= w_cout[k];
                r_dsk[DSK_OFF +: (k+1)*SW] <= w_dsk_nxt;
            end
        end

        if (k < int'(LAST)) begin : g_skew
            localparam int unsigned SKEW_OFF = k * WIDTH - SW * k * (k + 1) / 2;
            localparam int unsigned SKEW_LEN = WIDTH - (k + 1) * SW;

            logic [SKEW_LEN-1:0] w_a_nxt;
            logic [SKEW_LEN-1:0] w_b_nxt;

            if (k == 0) begin : g_src_in
                assign w_a_nxt = a[WIDTH-1:SW];
                assign w_b_nxt = w_b_eff[WIDTH-1:SW];
            end else begin : g_src_reg
                localparam int unsigned PREV_SKEW = (k - 1) * WIDTH - SW * (k - 1) * k / 2;
                assign w_a_nxt = r_skew_a[PREV_SKEW + SW +: SKEW_LEN];
                assign w_b_nxt = r_skew_b[PREV_SKEW + SW +: SKEW_LEN];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_skew_a[SKEW_OFF +: SKEW_LEN] <= '0;
                    r_skew_b[SKEW_OFF +: SKEW_LEN] <= '0;
                end else if (w_advance) begin
                    r_skew_a[SKEW_OFF +: SKEW_LEN] <= w_a_nxt;
                    r_skew_b[SKEW_OFF +: SKEW_LEN] <= w_b_nxt;
                end
            end
        end
    end

    // Carry into the MSB recovered from the MSB sum bit and its effective operands.
    assign w_msb_carry = w_sa[LAST][SW-1] ^ w_sb[LAST][SW-1] ^ w_ss[LAST][SW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_ovf <= w_msb_carry ^ w_cout[LAST];
        end
    end

    assign out_valid = r_valid[LAST];
    assign sum       = r_dsk[DSK_W-1 -: WIDTH];
    assign c_out     = r_carry[LAST];
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: default 32-bit instance with directed vectors and a 16-bit,
// one-block-per-stage instance with random traffic, both scored against an arithmetic model.
module tb_cla_pipe_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v32, rdy32, ov32, ordy32, c32, sub32, co32, of32;
    logic [31:0] a32, b32, s32;
    logic        v16, rdy16, ov16, ordy16, c16, sub16, co16, of16;
    logic [15:0] a16, b16, s16;

    int n_cmp = 0;
    int n_bad = 0;

    cla_pipe_adder u_dut32 (
        .clk (clk), .rst (rst), .in_valid (v32), .in_ready (rdy32), .a (a32), .b (b32),
        .c_in (c32), .sub (sub32), .out_valid (ov32), .out_ready (ordy32), .sum (s32),
        .c_out (co32), .ovf (of32)
    );

    cla_pipe_adder #(.WIDTH (16), .BLK (4), .BLK_PER_STAGE (1)) u_dut16 (
        .clk (clk), .rst (rst), .in_valid (v16), .in_ready (rdy16), .a (a16), .b (b16),
        .c_in (c16), .sub (sub16), .out_valid (ov16), .out_ready (ordy16), .sum (s16),
        .c_out (co16), .ovf (of16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, c_out, sum} packed from bit w+1 down; ovf from the signed-range rule.
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint unsigned mask, ua, ub, full;
        longint          sa, sb, res, lim;
        logic            o;
        mask = (64'd1 << w) - 64'd1;
        ua   = 64'(a) & mask;
        ub   = 64'(b) & mask;
        full = ua + ((sub ? ~ub : ub) & mask) + (sub ? 64'd1 : 64'(cin));
        lim  = longint'(64'd1 << (w - 1));
        sa   = (ua >= 64'(lim)) ? longint'(ua) - 2 * lim : longint'(ua);
        sb   = (ub >= 64'(lim)) ? longint'(ub) - 2 * lim : longint'(ub);
        res  = sub ? (sa - sb) : (sa + sb + longint'(64'(cin)));
        o    = (res >= lim) || (res < -lim);
        return (64'(o) << (w + 1)) | (full & ((mask << 1) | 64'd1));
    endfunction

    logic [63:0] q32[$];
    logic [63:0] q16[$];
    logic        hold32 = 1'b0, hold16 = 1'b0;
    logic [63:0] held32, held16;
    int          acc32 = 0, got32 = 0, acc16 = 0, got16 = 0;

    always @(negedge clk) begin
        if (rst) begin
            q32.delete();
            hold32 <= 1'b0;
        end else begin
            check("in_ready32", 64'(rdy32), 64'(!ov32 || ordy32));
            if (hold32) begin
                check("stall_valid32", 64'(ov32), 64'd1);
                check("stall_data32", 64'({of32, co32, s32}), held32);
            end
            if (ov32 && ordy32) begin
                check("result_expected32", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) begin
                    check("result32", 64'({of32, co32, s32}), q32.pop_front());
                    got32 <= got32 + 1;
                end
            end
            if (v32 && rdy32) begin
                q32.push_back(model(32, a32, b32, c32, sub32));
                acc32 <= acc32 + 1;
            end
            hold32 <= ov32 && !ordy32;
            held32 <= 64'({of32, co32, s32});
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q16.delete();
            hold16 <= 1'b0;
        end else begin
            check("in_ready16", 64'(rdy16), 64'(!ov16 || ordy16));
            if (hold16) begin
                check("stall_valid16", 64'(ov16), 64'd1);
                check("stall_data16", 64'({of16, co16, s16}), held16);
            end
            if (ov16 && ordy16) begin
                check("result_expected16", 64'(q16.size() != 0), 64'd1);
                if (q16.size() != 0) begin
                    check("result16", 64'({of16, co16, s16}), q16.pop_front());
                    got16 <= got16 + 1;
                end
            end
            if (v16 && rdy16) begin
                q16.push_back(model(16, {16'd0, a16}, {16'd0, b16}, c16, sub16));
                acc16 <= acc16 + 1;
            end
            hold16 <= ov16 && !ordy16;
            held16 <= 64'({of16, co16, s16});
        end
    end

    // One beat into an idle pipe; checks latency and hand-computed outputs.
    task automatic single32(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub, input logic [31:0] es,
                            input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        a32 = a; b32 = b; c32 = cin; sub32 = sub; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0; a32 = $urandom; b32 = $urandom; c32 = 1'($urandom); sub32 = 1'($urandom);
        lat = 1;
        while (!ov32 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sum"}, 64'(s32), 64'(es));
        check({tag, "_cout"}, 64'(co32), 64'(ec));
        check({tag, "_ovf"}, 64'(of32), 64'(eo));
    endtask

    initial begin
        int i, cyc, base;
        rst = 1'b1;
        v32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0; sub32 = 1'b0; ordy32 = 1'b1;
        v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b1;

        check("model_pin_wrap", model(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0), 64'h1_0000_0000);
        check("model_pin_ovf", model(32, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0), 64'h2_8000_0000);
        check("model_pin_sub16", model(16, 32'h8000, 32'h1, 1'b0, 1'b1), 64'h3_7FFF);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(ov32), 64'd0);
        check("reset_sum", 64'(s32), 64'd0);
        check("reset_cout", 64'(co32), 64'd0);
        check("reset_ovf", 64'(of32), 64'd0);
        check("reset_in_ready", 64'(rdy32), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        single32("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        single32("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single32("sub57", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        single32("sub75", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);

        // Eight back-to-back beats against out_ready pattern 1,0,0,1,...
        base = got32;
        i = 0;
        cyc = 0;
        while ((got32 - base) < 8 && cyc < 100) begin
            @(posedge clk); #1;
            ordy32 = (cyc % 4 == 0) || (cyc % 4 == 3);
            v32    = (i < 8);
            a32    = 32'(i) * 32'h1111_1111 + 32'h0F00_0000;
            b32    = 32'h0F0F_0F0F ^ 32'(i);
            sub32  = i[0];
            c32    = i[1];
            @(negedge clk);
            if (v32 && rdy32) i++;
            cyc++;
        end
        check("burst_delivered", 64'(got32 - base), 64'd8);
        @(posedge clk); #1;
        v32 = 1'b0;
        ordy32 = 1'b1;
        repeat (6) @(posedge clk);

        // Three beats in flight, then a one-cycle reset discards them.
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            v32 = 1'b1; a32 = $urandom; b32 = $urandom; c32 = 1'b1; sub32 = 1'b0;
        end
        base = got32;
        @(posedge clk); #1;
        v32 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_valid", 64'(ov32), 64'd0);
        check("post_rst_sum", 64'(s32), 64'd0);
        check("post_rst_cout", 64'(co32), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        check("no_ghost_results", 64'(got32 - base), 64'd0);
        single32("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0,
                 1'b0);

        // Random traffic on the 16-bit, one-block-per-stage instance.
        base = acc16;
        cyc = 0;
        while ((acc16 - base) < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            v16    = ($urandom_range(3) != 0);
            a16    = 16'($urandom);
            b16    = 16'($urandom);
            c16    = 1'($urandom);
            sub16  = 1'($urandom);
            ordy16 = ($urandom_range(3) != 0);
            cyc++;
        end
        check("random_beats16", 64'(acc16 - base), 64'd1000);
        @(posedge clk); #1;
        v16 = 1'b0;
        ordy16 = 1'b1;
        cyc = 0;
        while ((q16.size() != 0 || q32.size() != 0) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain16", 64'(q16.size()), 64'd0);
        check("drain32", 64'(q32.size()), 64'd0);
        check("delivered16", 64'(got16), 64'(acc16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
